multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have one parameter: USE_MEM_READY, default 1; when 0, mem_ready is treated as constant 1.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 instr  in  32  current instruction register contents.
REQ-005 zero  in  2  ALU flags; bit0 = result equal/zero, bit1 = less-than true.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 pc_we, ir_we, mem_we, rf_we  out  1 each  PC, IR, data-memory and register-file write enables.
REQ-008 adr_sel  out  1  memory address source: 0 = PC, 1 = ALU-out register.
REQ-009 result_sel  out  2  writeback source: 0 = ALU-out register, 1 = memory data, 2 = live ALU result.
REQ-010 alu_src1_sel  out  2  ALU source 1 select: 0 = PC, 1 = PC_old, 2 = rs1.
REQ-011 alu_src2_sel  out  2  ALU source 2 select: 0 = rs2, 1 = imm_ext, 2 = constant 4.
REQ-012 alu_ctrl  out  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
REQ-013 imm_sel  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
REQ-014 illegal  out  1  sticky flag: unsupported opcode decoded.

Function
REQ-015 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, JAL, JALR, BRANCH, LUI, TRAP.
REQ-016 FETCH: adr_sel=0, alu 0/2/add, result_sel=2; ir_we and pc_we asserted only when mem_ready=1; the FSM stays in FETCH while mem_ready=0.
REQ-017 DECODE: alu 1/1/add, precomputing PC_old+imm into the ALU-out register; next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1101111 -> JAL, 1100111 -> JALR, 1100011 -> BRANCH, 0110111 -> LUI, any other opcode -> TRAP.
REQ-018 MEMADR: alu 2/1/add; next state MEMRD for loads, MEMWR for stores.
REQ-019 MEMRD: adr_sel=1; held until mem_ready, then -> MEMWB. MEMWB: result_sel=1, rf_we=1, -> FETCH.
REQ-020 MEMWR: adr_sel=1, mem_we=1 held until mem_ready, then -> FETCH; mem_we SHALL deassert in the cycle after acceptance.
REQ-021 EXEC_R: alu 2/0, alu_ctrl from funct3/funct7[5]. EXEC_I: alu 2/1, funct7[5] used only for the srai shift. Both -> ALUWB. ALUWB: result_sel=0, rf_we=1, -> FETCH.
REQ-022 JAL: alu 1/2/add, result_sel=0, pc_we=1, -> ALUWB, writing PC_old+4 to rd. JALR: alu 2/1/add, result_sel=2, pc_we=1, -> ALUWB.
REQ-023 BRANCH: alu 2/0; beq/bne use sub and zero[0], blt/bge use slt and zero[1], bltu/bgeu use sltu and zero[1]; result_sel=0; pc_we = taken condition; -> FETCH.
REQ-024 LUI: imm_sel=3; rd receives imm_ext via result_sel=2 with src1 forced to constant 0 through alu 2/1 on x0 (rs1 field zeroed by decoder); -> FETCH after writeback in the same cycle (rf_we=1).
REQ-025 TRAP: all write enables 0, illegal=1; the FSM SHALL remain in TRAP until reset.
REQ-026 Write-enable outputs SHALL be 0 in every state not listed as asserting them; alu_ctrl SHALL default to add.
REQ-027 Instruction latency SHALL be: loads 5 cycles, stores/R/I/JAL/JALR 4, branch 3, LUI 3, each plus memory wait cycles.

Reset
REQ-028 While rst_n=0, the state SHALL be FETCH, illegal=0, and all write enables 0; an assertion mid-instruction aborts it with no further writes.
REQ-029 The first FETCH SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-030 ctrl_pkg SHALL hold the state enum, the alu_ctrl, src-select, result_sel and imm_sel constants, and the opcode constants.
REQ-031 Sub-module alu_decoder SHALL map {state class, funct3, funct7[5]} to alu_ctrl combinationally.

Verification
REQ-032 add x3,x1,x2 with mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB; rf_we=1 only in cycle 4.
REQ-033 lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, rf_we asserted once in MEMWB.
REQ-034 beq with zero=01 -> pc_we=1 in BRANCH; with zero=00 -> pc_we=0.
REQ-035 bltu with zero=10 -> alu_ctrl=6 and pc_we=1.
REQ-036 opcode 0000000 -> TRAP, illegal=1 held for 10+ cycles, all write enables 0.
REQ-037 rst_n pulsed low during MEMWR -> mem_we=0 immediately, state FETCH after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Purpose: shared types and encodings for the multicycle RISC-V controller.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a. Holds FSM states, ALU/mux/immediate encodings and opcodes.
package ctrl_pkg;

  // Controller states, one per micro-step of an instruction.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JAL,
    S_JALR,
    S_BRANCH,
    S_LUI,
    S_TRAP
  } state_e;

  // How the ALU decoder should interpret funct3/funct7[5] in a given state.
  typedef enum logic [1:0] {
    CLS_ADD,   // address / PC arithmetic: always add
    CLS_R,     // register-register op
    CLS_I,     // register-immediate op
    CLS_BR     // branch compare
  } alu_class_e;

  // alu_ctrl encodings
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // ALU source 1 select
  localparam logic [1:0] SRC1_PC     = 2'd0;
  localparam logic [1:0] SRC1_PC_OLD = 2'd1;
  localparam logic [1:0] SRC1_RS1    = 2'd2;

  // ALU source 2 select
  localparam logic [1:0] SRC2_RS2  = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;
  localparam logic [1:0] SRC2_FOUR = 2'd2;

  // Writeback / PC-next source select
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_MEMDATA = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate format implied by an opcode; anything not listed is I-type.
  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_LUI:    return IMM_U;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Purpose: maps {state class, funct3, funct7[5]} to the ALU opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none. Ports: cls_i, funct3_i, funct7b5_i in; alu_ctrl_o out.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_e  cls_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      CLS_R: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = funct7b5_i ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_I: begin
        // Immediate forms have no subtract; bit 30 only selects srai vs srli.
        case (funct3_i)
          3'b000:  alu_ctrl_o = ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_BR: begin
        // funct3[2:1]: 00 eq/ne, 10 signed lt/ge, 11 unsigned lt/ge.
        case (funct3_i[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle RISC-V (RV32I subset) control FSM driving datapath muxes/enables.
// Latency: load 5, store/R/I/JAL/JALR 4, branch/LUI 3 cycles, plus memory wait cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0 (tied high if USE_MEM_READY=0).
// Ports: clk, rst_n, instr (IR), zero (bit0 eq, bit1 lt), mem_ready in;
//        pc_we/ir_we/mem_we/rf_we, adr_sel, result_sel, alu_src1_sel, alu_src2_sel,
//        alu_ctrl, imm_sel, illegal (sticky until reset) out.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [1:0]  zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_we,
  output logic        rf_we,
  output logic        adr_sel,
  output logic [1:0]  result_sel,
  output logic [1:0]  alu_src1_sel,
  output logic [1:0]  alu_src2_sel,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  imm_sel,
  output logic        illegal
);

  state_e     state_q, state_d;
  alu_class_e alu_cls;
  logic       mem_rdy;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       br_flag;
  logic       br_taken;
  logic       unused_instr;

  assign mem_rdy  = USE_MEM_READY ? mem_ready : 1'b1;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Register indices and the rest of funct7 are datapath concerns only.
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Signed/unsigned compares report via zero[1], eq/ne via zero[0];
  // funct3[0] inverts the sense (bne/bge/bgeu).
  assign br_flag  = funct3[2] ? zero[1] : zero[0];
  assign br_taken = br_flag ^ funct3[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_JALR:   state_d = S_ALUWB;
      S_BRANCH: state_d = S_FETCH;
      S_LUI:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    adr_sel      = 1'b0;
    result_sel   = RES_ALUOUT;
    alu_src1_sel = SRC1_PC;
    alu_src2_sel = SRC2_RS2;
    alu_cls      = CLS_ADD;
    imm_sel      = imm_fmt(opcode);
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight to the PC; the IR latches once memory answers.
        alu_src1_sel = SRC1_PC;
        alu_src2_sel = SRC2_FOUR;
        result_sel   = RES_ALU;
        ir_we        = mem_rdy;
        pc_we        = mem_rdy;
      end
      S_DECODE: begin
        // Speculative branch/jump target PC_old+imm into the ALU-out register.
        alu_src1_sel = SRC1_PC_OLD;
        alu_src2_sel = SRC2_IMM;
      end
      S_MEMADR: begin
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_IMM;
      end
      S_MEMRD: adr_sel = 1'b1;
      S_MEMWB: begin
        result_sel = RES_MEMDATA;
        rf_we      = 1'b1;
      end
      S_MEMWR: begin
        adr_sel = 1'b1;
        mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_RS2;
        alu_cls      = CLS_R;
      end
      S_EXEC_I: begin
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_IMM;
        alu_cls      = CLS_I;
      end
      S_ALUWB: begin
        result_sel = RES_ALUOUT;
        rf_we      = 1'b1;
      end
      S_JAL: begin
        // Target (from DECODE) loads the PC while PC_old+4 is computed for rd.
        alu_src1_sel = SRC1_PC_OLD;
        alu_src2_sel = SRC2_FOUR;
        result_sel   = RES_ALUOUT;
        pc_we        = 1'b1;
      end
      S_JALR: begin
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_IMM;
        result_sel   = RES_ALU;
        pc_we        = 1'b1;
      end
      S_BRANCH: begin
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_RS2;
        alu_cls      = CLS_BR;
        result_sel   = RES_ALUOUT;
        pc_we        = br_taken;
      end
      S_LUI: begin
        // Decoder zeroes rs1 for LUI, so rs1+imm is just the U immediate.
        imm_sel      = IMM_U;
        alu_src1_sel = SRC1_RS1;
        alu_src2_sel = SRC2_IMM;
        result_sel   = RES_ALU;
        rf_we        = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
    // FETCH is the reset state and would otherwise assert ir_we/pc_we
    // combinationally from mem_ready while reset is still held.
    if (!rst_n) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_we = 1'b0;
      rf_we  = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .cls_i      (alu_cls),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctrl_o (alu_ctrl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: self-checking bench for multicycle_ctrl; per-instruction expected cycle
// sequences are built from instruction class, memory wait counts and branch flags.
// Latency/backpressure: mem_ready stalls are injected in FETCH, MEMRD and MEMWR.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [1:0]  zero;
  logic        mem_ready;
  logic        pc_we, ir_we, mem_we, rf_we, adr_sel, illegal;
  logic [1:0]  result_sel, alu_src1_sel, alu_src2_sel;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_sel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int DC = -1;  // field not constrained in this cycle

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_JAL = 7'b1101111, T_JALR = 7'b1100111,
                         T_BR = 7'b1100011, T_LUI = 7'b0110111;

  // Output vector: {pc,ir,mem,rf we[18:15], adr[14], res[13:12], s1[11:10], s2[9:8], alu[7:4], imm[3:1], ill[0]}
  typedef struct packed {
    logic [18:0] exp;
    logic [18:0] msk;
    logic        mrdy;
  } step_t;

  step_t q[$];

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_we        (pc_we),
    .ir_we        (ir_we),
    .mem_we       (mem_we),
    .rf_we        (rf_we),
    .adr_sel      (adr_sel),
    .result_sel   (result_sel),
    .alu_src1_sel (alu_src1_sel),
    .alu_src2_sel (alu_src2_sel),
    .alu_ctrl     (alu_ctrl),
    .imm_sel      (imm_sel),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {pc_we, ir_we, mem_we, rf_we, adr_sel, result_sel, alu_src1_sel,
            alu_src2_sel, alu_ctrl, imm_sel, illegal};
  endfunction

  // ISA-level expected ALU operations
  function automatic logic [3:0] ref_alu_r(input logic [2:0] f3, input logic b30);
    case (f3)
      3'd0:    return b30 ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return b30 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu_i(input logic [2:0] f3, input logic b30);
    if (f3 == 3'd0) return 4'd0;
    return ref_alu_r(f3, b30);
  endfunction

  function automatic logic [3:0] ref_alu_br(input logic [2:0] f3);
    if (f3 == 3'd6 || f3 == 3'd7) return 4'd6;
    if (f3 == 3'd4 || f3 == 3'd5) return 4'd5;
    return 4'd1;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [1:0] z);
    case (f3)
      3'd0:    return z[0];
      3'd1:    return !z[0];
      3'd4:    return z[1];
      3'd5:    return !z[1];
      3'd6:    return z[1];
      3'd7:    return !z[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic [3:0] we, input int adr, input int rs, input int s1,
                      input int s2, input logic [3:0] alu, input int imm, input logic ill,
                      input int mr);
    step_t s;
    s.exp = '0;
    s.msk = '0;
    s.exp[18:15] = we;       s.msk[18:15] = 4'hF;
    s.exp[7:4]   = alu;      s.msk[7:4]   = 4'hF;
    s.exp[0]     = ill;      s.msk[0]     = 1'b1;
    if (adr >= 0) begin s.exp[14]    = adr[0];   s.msk[14]    = 1'b1;  end
    if (rs  >= 0) begin s.exp[13:12] = rs[1:0];  s.msk[13:12] = 2'b11; end
    if (s1  >= 0) begin s.exp[11:10] = s1[1:0];  s.msk[11:10] = 2'b11; end
    if (s2  >= 0) begin s.exp[9:8]   = s2[1:0];  s.msk[9:8]   = 2'b11; end
    if (imm >= 0) begin s.exp[3:1]   = imm[2:0]; s.msk[3:1]   = 3'b111; end
    s.mrdy = (mr < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
    q.push_back(s);
  endtask

  // Builds the expected cycle sequence of one instruction, then drives and checks it.
  // Entered and left on a falling edge. stop_after >= 0 truncates after that step.
  task automatic run_instr(input logic [31:0] ins, input logic [1:0] z, input int fw,
                           input int mw, input int stop_after, input string name);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;
    op  = ins[6:0];
    f3  = ins[14:12];
    b30 = ins[30];
    q.delete();
    for (int i = 0; i < fw; i++) push(4'b0000, 0, 2, 0, 2, 4'd0, DC, 1'b0, 0);
    push(4'b1100, 0, 2, 0, 2, 4'd0, DC, 1'b0, 1);
    push(4'b0000, DC, DC, 1, 1, 4'd0, DC, 1'b0, DC);
    case (op)
      T_LOAD: begin
        push(4'b0000, DC, DC, 2, 1, 4'd0, DC, 1'b0, DC);
        for (int i = 0; i < mw; i++) push(4'b0000, 1, DC, DC, DC, 4'd0, DC, 1'b0, 0);
        push(4'b0000, 1, DC, DC, DC, 4'd0, DC, 1'b0, 1);
        push(4'b0001, DC, 1, DC, DC, 4'd0, DC, 1'b0, DC);
      end
      T_STORE: begin
        push(4'b0000, DC, DC, 2, 1, 4'd0, DC, 1'b0, DC);
        for (int i = 0; i < mw; i++) push(4'b0010, 1, DC, DC, DC, 4'd0, DC, 1'b0, 0);
        push(4'b0010, 1, DC, DC, DC, 4'd0, DC, 1'b0, 1);
      end
      T_R: begin
        push(4'b0000, DC, DC, 2, 0, ref_alu_r(f3, b30), DC, 1'b0, DC);
        push(4'b0001, DC, 0, DC, DC, 4'd0, DC, 1'b0, DC);
      end
      T_I: begin
        push(4'b0000, DC, DC, 2, 1, ref_alu_i(f3, b30), DC, 1'b0, DC);
        push(4'b0001, DC, 0, DC, DC, 4'd0, DC, 1'b0, DC);
      end
      T_JAL: begin
        push(4'b1000, DC, 0, 1, 2, 4'd0, DC, 1'b0, DC);
        push(4'b0001, DC, 0, DC, DC, 4'd0, DC, 1'b0, DC);
      end
      T_JALR: begin
        push(4'b1000, DC, 2, 2, 1, 4'd0, DC, 1'b0, DC);
        push(4'b0001, DC, 0, DC, DC, 4'd0, DC, 1'b0, DC);
      end
      T_BR: push({ref_taken(f3, z), 3'b000}, DC, 0, 2, 0, ref_alu_br(f3), DC, 1'b0, DC);
      T_LUI: push(4'b0001, DC, 2, 2, 1, 4'd0, 3, 1'b0, DC);
      default: for (int i = 0; i < 12; i++) push(4'b0000, DC, DC, DC, DC, 4'd0, DC, 1'b1, DC);
    endcase
    instr = ins;
    zero  = z;
    for (int i = 0; i < q.size(); i++) begin
      if (stop_after >= 0 && i > stop_after) break;
      mem_ready = q[i].mrdy;
      #1;
      check($sformatf("%s.cyc%0d", name, i), 32'(obs() & q[i].msk), 32'(q[i].exp));
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_instr(input int cls);
    logic [31:0] w;
    int br_f3[6] = '{0, 1, 4, 5, 6, 7};
    w = $urandom;
    case (cls)
      0: w[6:0] = T_LOAD;
      1: w[6:0] = T_STORE;
      2: w[6:0] = T_R;
      3: w[6:0] = T_I;
      4: w[6:0] = T_JAL;
      5: w[6:0] = T_JALR;
      6: begin
        w[6:0]   = T_BR;
        w[14:12] = 3'(br_f3[$urandom_range(0, 5)]);
      end
      default: w[6:0] = T_LUI;
    endcase
    return w;
  endfunction

  initial begin
    rst_n     = 1'b0;
    instr     = 32'h0;
    zero      = 2'b00;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    // Reset: FETCH outputs, but no write enables even with mem_ready high.
    check("rst_we", {28'h0, pc_we, ir_we, mem_we, rf_we}, 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_adr_sel", 32'(adr_sel), 32'h0);
    check("rst_result_sel", 32'(result_sel), 32'd2);
    check("rst_src2", 32'(alu_src2_sel), 32'd2);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    run_instr(32'h002081B3, 2'b00, 0, 0, -1, "add_x3_x1_x2");
    run_instr(32'h0000A283, 2'b00, 0, 3, -1, "lw_wait3");
    run_instr(32'h00208063, 2'b01, 0, 0, -1, "beq_taken");
    run_instr(32'h00208063, 2'b00, 1, 0, -1, "beq_not_taken");
    run_instr(32'h0020E063, 2'b10, 0, 0, -1, "bltu_taken");
    run_instr(32'h4020D093, 2'b00, 0, 0, -1, "srai");
    run_instr(32'h123450B7, 2'b00, 2, 0, -1, "lui");

    for (int n = 0; n < 200; n++) begin
      int cls;
      cls = $urandom_range(0, 7);
      run_instr(rand_instr(cls), 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                $urandom_range(0, 3), -1, $sformatf("rnd%0d_c%0d", n, cls));
    end

    // Unsupported opcode: TRAP, illegal held, no writes for 12 cycles.
    run_instr(32'h0000_0000, 2'b00, 1, 0, -1, "trap_op0");

    rst_n = 1'b0;
    #1;
    check("trap_cleared_by_reset", 32'(illegal), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store stalled in MEMWR, then reset asserted mid-access.
    run_instr(32'h0020A023, 2'b00, 0, 3, 3, "sw_abort");
    mem_ready = 1'b0;
    #1;
    check("sw_memwr_hold", 32'(mem_we), 32'h1);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("abort_we_now", {28'h0, pc_we, ir_we, mem_we, rf_we}, 32'h0);
    @(negedge clk);
    check("abort_we_held", {28'h0, pc_we, ir_we, mem_we, rf_we}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_reset_fetch_we", {28'h0, pc_we, ir_we, mem_we, rf_we}, 32'hC);
    check("post_reset_fetch_adr", 32'(adr_sel), 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("post_reset_decode_src1", 32'(alu_src1_sel), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
